// File: rtl/rs_pkg.sv
// Shared types and default widths for the reservation station.
// Entry layout: busy, op, destination tag, two source operands.
package rs_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int TAG_WIDTH    = 7;
  localparam int OPCODE_WIDTH = 7;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } operand_t;

  typedef struct packed {
    logic                    busy;
    logic [OPCODE_WIDTH-1:0] op;
    logic [TAG_WIDTH-1:0]    tag;
    operand_t                src1;
    operand_t                src2;
  } rs_entry_t;

endpackage

// File: rtl/rs_priority_select.sv
// Lowest-index picker: one-hot grant plus encoded index.
// Used for free-slot allocation and for issue selection.
module rs_priority_select #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // scan from the top so the lowest set request wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Single-issue reservation station with broadcast snooping.
// Optional same-cycle wakeup: define RS_WAKEUP_BYPASS_EN.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = rs_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH    = rs_pkg::TAG_WIDTH,
  parameter int OPCODE_WIDTH = rs_pkg::OPCODE_WIDTH,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    halt,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [OPCODE_WIDTH-1:0] dispatch_op,
  input  logic [TAG_WIDTH-1:0]    dispatch_tag,
  input  logic [TAG_WIDTH-1:0]    rs1_tag,
  input  logic [TAG_WIDTH-1:0]    rs2_tag,
  input  logic                    rs1_dataValid,
  input  logic                    rs2_dataValid,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  input  logic                    broadcastDataAvailable,
  input  logic [TAG_WIDTH-1:0]    broadcastDestinationTag,
  input  logic [DATA_WIDTH-1:0]   broadcastDestinationData,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [OPCODE_WIDTH-1:0] issue_op,
  output logic [TAG_WIDTH-1:0]    issue_tag,
  output logic [DATA_WIDTH-1:0]   issue_rs1,
  output logic [DATA_WIDTH-1:0]   issue_rs2,
  output logic [CW-1:0]           occupancy
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] v1_q, v1_d;
  logic [DEPTH-1:0] v2_q, v2_d;

  logic [OPCODE_WIDTH-1:0] op_q [DEPTH];
  logic [OPCODE_WIDTH-1:0] op_d [DEPTH];
  logic [TAG_WIDTH-1:0]    tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]    tag_d [DEPTH];
  logic [TAG_WIDTH-1:0]    t1_q [DEPTH];
  logic [TAG_WIDTH-1:0]    t1_d [DEPTH];
  logic [TAG_WIDTH-1:0]    t2_q [DEPTH];
  logic [TAG_WIDTH-1:0]    t2_d [DEPTH];
  logic [DATA_WIDTH-1:0]   d1_q [DEPTH];
  logic [DATA_WIDTH-1:0]   d1_d [DEPTH];
  logic [DATA_WIDTH-1:0]   d2_q [DEPTH];
  logic [DATA_WIDTH-1:0]   d2_d [DEPTH];

  logic [DEPTH-1:0] hit1, hit2;
  logic [DEPTH-1:0] ok1, ok2;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] alloc_gnt, iss_gnt;
  logic [IW-1:0]    alloc_idx, iss_idx;
  logic             in_hit1, in_hit2;
  logic             dispatch_fire, issue_fire;

  // per-entry broadcast match and operand readiness
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = broadcastDataAvailable &
                (t1_q[i] == broadcastDestinationTag);
      hit2[i] = broadcastDataAvailable &
                (t2_q[i] == broadcastDestinationTag);
    end
`ifdef RS_WAKEUP_BYPASS_EN
    ok1 = v1_q | hit1;
    ok2 = v2_q | hit2;
`else
    ok1 = v1_q;
    ok2 = v2_q;
`endif
    rdy = busy_q & ok1 & ok2;
  end

  rs_priority_select #(.N(DEPTH)) u_alloc (
    .req (~busy_q),
    .gnt (alloc_gnt),
    .idx (alloc_idx)
  );

  rs_priority_select #(.N(DEPTH)) u_issue (
    .req (rdy),
    .gnt (iss_gnt),
    .idx (iss_idx)
  );

  assign dispatch_ready = (|alloc_gnt) & ~halt;
  assign issue_valid    = (|iss_gnt) & ~halt;
  assign dispatch_fire  = dispatch_valid & dispatch_ready;
  assign issue_fire     = issue_valid & issue_ready;

  assign in_hit1 = broadcastDataAvailable &
                   (rs1_tag == broadcastDestinationTag);
  assign in_hit2 = broadcastDataAvailable &
                   (rs2_tag == broadcastDestinationTag);

  // issue payload from the selected entry, zero when idle
  always_comb begin
    issue_op  = '0;
    issue_tag = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    if (|iss_gnt) begin
      issue_op  = op_q[iss_idx];
      issue_tag = tag_q[iss_idx];
      issue_rs1 = d1_q[iss_idx];
      issue_rs2 = d2_q[iss_idx];
`ifdef RS_WAKEUP_BYPASS_EN
      if (!v1_q[iss_idx]) issue_rs1 = broadcastDestinationData;
      if (!v2_q[iss_idx]) issue_rs2 = broadcastDestinationData;
`endif
    end
  end

  // entries in use
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + CW'(busy_q[i]);
  end

  // next state: snoop, retire the issued slot, allocate a new one
  always_comb begin
    busy_d = busy_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]  = op_q[i];
      tag_d[i] = tag_q[i];
      t1_d[i]  = t1_q[i];
      t2_d[i]  = t2_q[i];
      d1_d[i]  = d1_q[i];
      d2_d[i]  = d2_q[i];
      if (busy_q[i] & ~v1_q[i] & hit1[i]) begin
        v1_d[i] = 1'b1;
        d1_d[i] = broadcastDestinationData;
      end
      if (busy_q[i] & ~v2_q[i] & hit2[i]) begin
        v2_d[i] = 1'b1;
        d2_d[i] = broadcastDestinationData;
      end
    end
    if (issue_fire)
      busy_d = busy_d & ~iss_gnt;
    if (dispatch_fire) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = dispatch_op;
      tag_d[alloc_idx]  = dispatch_tag;
      t1_d[alloc_idx]   = rs1_tag;
      t2_d[alloc_idx]   = rs2_tag;
      v1_d[alloc_idx]   = rs1_dataValid | in_hit1;
      v2_d[alloc_idx]   = rs2_dataValid | in_hit2;
      d1_d[alloc_idx]   = rs1_dataValid ? rs1_data
                                        : broadcastDestinationData;
      d2_d[alloc_idx]   = rs2_dataValid ? rs2_data
                                        : broadcastDestinationData;
    end
  end

  // entry storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        tag_q[i] <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        d1_q[i]  <= '0;
        d2_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= op_d[i];
        tag_q[i] <= tag_d[i];
        t1_q[i]  <= t1_d[i];
        t2_q[i]  <= t2_d[i];
        d1_q[i]  <= d1_d[i];
        d2_q[i]  <= d2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: entry-array model plus directed checks.
// Honours RS_WAKEUP_BYPASS_EN the same way as the design.
module tb_reservation_station;
  import rs_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt;
  logic        dispatch_valid, dispatch_ready;
  logic [6:0]  dispatch_op, dispatch_tag;
  logic [6:0]  rs1_tag, rs2_tag;
  logic        rs1_dataValid, rs2_dataValid;
  logic [31:0] rs1_data, rs2_data;
  logic        broadcastDataAvailable;
  logic [6:0]  broadcastDestinationTag;
  logic [31:0] broadcastDestinationData;
  logic        issue_valid, issue_ready;
  logic [6:0]  issue_op, issue_tag;
  logic [31:0] issue_rs1, issue_rs2;
  logic [3:0]  occupancy;

  reservation_station dut (
    .clk                      (clk),
    .rst                      (rst),
    .halt                     (halt),
    .dispatch_valid           (dispatch_valid),
    .dispatch_ready           (dispatch_ready),
    .dispatch_op              (dispatch_op),
    .dispatch_tag             (dispatch_tag),
    .rs1_tag                  (rs1_tag),
    .rs2_tag                  (rs2_tag),
    .rs1_dataValid            (rs1_dataValid),
    .rs2_dataValid            (rs2_dataValid),
    .rs1_data                 (rs1_data),
    .rs2_data                 (rs2_data),
    .broadcastDataAvailable   (broadcastDataAvailable),
    .broadcastDestinationTag  (broadcastDestinationTag),
    .broadcastDestinationData (broadcastDestinationData),
    .issue_valid              (issue_valid),
    .issue_ready              (issue_ready),
    .issue_op                 (issue_op),
    .issue_tag                (issue_tag),
    .issue_rs1                (issue_rs1),
    .issue_rs2                (issue_rs2),
    .occupancy                (occupancy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  rs_entry_t m [DEPTH];
  int        cnt, sel, fr;
  logic      e_dr, e_iv;
  logic [6:0]  e_op, e_tag;
  logic [31:0] e_rs1, e_rs2;
  rs_entry_t   ne;

  function automatic logic bhit(operand_t o);
    return broadcastDataAvailable && (o.tag == broadcastDestinationTag);
  endfunction

  function automatic logic opok(operand_t o);
`ifdef RS_WAKEUP_BYPASS_EN
    return o.valid || bhit(o);
`else
    return o.valid;
`endif
  endfunction

  function automatic operand_t incoming(logic v, logic [6:0] t,
                                        logic [31:0] d);
    operand_t o;
    o.tag   = t;
    o.valid = v || (broadcastDataAvailable &&
                    t == broadcastDestinationTag);
    o.data  = v ? d : broadcastDestinationData;
    return o;
  endfunction

  always @(negedge clk) begin
    if (!rst)
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
    cnt = 0; sel = -1; fr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) cnt++;
      else if (fr < 0) fr = i;
      if (sel < 0 && m[i].busy && opok(m[i].src1) && opok(m[i].src2))
        sel = i;
    end
    e_dr = (cnt < DEPTH) && !halt;
    e_iv = (sel >= 0) && !halt;
    e_op = '0; e_tag = '0; e_rs1 = '0; e_rs2 = '0;
    if (sel >= 0) begin
      e_op  = m[sel].op;
      e_tag = m[sel].tag;
      e_rs1 = m[sel].src1.valid ? m[sel].src1.data
                                : broadcastDestinationData;
      e_rs2 = m[sel].src2.valid ? m[sel].src2.data
                                : broadcastDestinationData;
    end
    chk("m_dispatch_ready", dispatch_ready, e_dr);
    chk("m_issue_valid", issue_valid, e_iv);
    chk("m_issue_op", issue_op, e_op);
    chk("m_issue_tag", issue_tag, e_tag);
    chk("m_issue_rs1", issue_rs1, e_rs1);
    chk("m_issue_rs2", issue_rs2, e_rs2);
    chk("m_occupancy", occupancy, cnt);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].busy && !m[i].src1.valid && bhit(m[i].src1)) begin
          m[i].src1.valid = 1'b1;
          m[i].src1.data  = broadcastDestinationData;
        end
        if (m[i].busy && !m[i].src2.valid && bhit(m[i].src2)) begin
          m[i].src2.valid = 1'b1;
          m[i].src2.data  = broadcastDestinationData;
        end
      end
      if (e_iv && issue_ready) m[sel].busy = 1'b0;
      if (dispatch_valid && e_dr) begin
        ne.busy = 1'b1;
        ne.op   = dispatch_op;
        ne.tag  = dispatch_tag;
        ne.src1 = incoming(rs1_dataValid, rs1_tag, rs1_data);
        ne.src2 = incoming(rs2_dataValid, rs2_tag, rs2_data);
        m[fr]   = ne;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [6:0] op, input logic [6:0] tg,
                      input logic [6:0] t1, input logic v1,
                      input logic [31:0] d1,
                      input logic [6:0] t2, input logic v2,
                      input logic [31:0] d2);
    dispatch_valid = 1'b1;
    dispatch_op    = op;
    dispatch_tag   = tg;
    rs1_tag = t1; rs1_dataValid = v1; rs1_data = d1;
    rs2_tag = t2; rs2_dataValid = v2; rs2_data = d2;
  endtask

  logic [6:0]  hold_tag;
  logic [31:0] hold_rs1;

  initial begin
    rst = 1'b0; halt = 1'b0;
    dispatch_valid = 1'b0; dispatch_op = '0; dispatch_tag = '0;
    rs1_tag = '0; rs2_tag = '0;
    rs1_dataValid = 1'b0; rs2_dataValid = 1'b0;
    rs1_data = '0; rs2_data = '0;
    broadcastDataAvailable = 1'b0;
    broadcastDestinationTag = '0;
    broadcastDestinationData = '0;
    issue_ready = 1'b0;
    repeat (3) step();
    chk("rst_issue_valid", issue_valid, 1'b0);
    chk("rst_dispatch_ready", dispatch_ready, 1'b1);
    chk("rst_occupancy", occupancy, 4'd0);
    rst = 1'b1;
    step();

    // both operands ready at dispatch
    issue_ready = 1'b1;
    disp(7'h33, 7'd5, 7'd0, 1'b1, 32'd10, 7'd0, 1'b1, 32'd20);
    step();
    dispatch_valid = 1'b0;
    chk("t1_issue_valid", issue_valid, 1'b1);
    chk("t1_issue_rs1", issue_rs1, 32'd10);
    chk("t1_issue_rs2", issue_rs2, 32'd20);
    chk("t1_issue_tag", issue_tag, 7'd5);
    chk("t1_issue_op", issue_op, 7'h33);
    step();
    chk("t1_occ_after", occupancy, 4'd0);

    // rs1 waits on tag 9, broadcast two cycles later
    disp(7'h13, 7'd3, 7'd9, 1'b0, 32'd0, 7'd0, 1'b1, 32'd1);
    step();
    dispatch_valid = 1'b0;
    chk("t2_wait", issue_valid, 1'b0);
    step();
    broadcastDataAvailable = 1'b1;
    broadcastDestinationTag = 7'd9;
    broadcastDestinationData = 32'hDEAD;
    #1;
`ifdef RS_WAKEUP_BYPASS_EN
    chk("t2_bypass_valid", issue_valid, 1'b1);
    chk("t2_bypass_rs1", issue_rs1, 32'hDEAD);
`else
    chk("t2_nobypass_valid", issue_valid, 1'b0);
`endif
    step();
    broadcastDataAvailable = 1'b0;
    #1;
`ifdef RS_WAKEUP_BYPASS_EN
    chk("t2_gone", occupancy, 4'd0);
`else
    chk("t2_late_valid", issue_valid, 1'b1);
    chk("t2_late_rs1", issue_rs1, 32'hDEAD);
`endif
    step();
    chk("t2_occ", occupancy, 4'd0);

    // dispatch-cycle snoop of rs2
    disp(7'h01, 7'd6, 7'd0, 1'b1, 32'd2, 7'd4, 1'b0, 32'd0);
    broadcastDataAvailable = 1'b1;
    broadcastDestinationTag = 7'd4;
    broadcastDestinationData = 32'd7;
    step();
    dispatch_valid = 1'b0;
    broadcastDataAvailable = 1'b0;
    #1;
    chk("t3_valid", issue_valid, 1'b1);
    chk("t3_rs2", issue_rs2, 32'd7);
    step();

    // fill all entries
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(7'(i), 7'(10 + i), 7'd0, 1'b1, 32'(i),
           7'd0, 1'b1, 32'(i + 100));
      step();
    end
    chk("t4_full_ready", dispatch_ready, 1'b0);
    chk("t4_full_occ", occupancy, 4'd8);
    disp(7'h7f, 7'd99, 7'd0, 1'b1, 32'd0, 7'd0, 1'b1, 32'd0);
    step();
    dispatch_valid = 1'b0;
    chk("t4_ignored_occ", occupancy, 4'd8);
    issue_ready = 1'b1;
    #1;
    chk("t4_no_reopen", dispatch_ready, 1'b0);
    chk("t4_issue_tag", issue_tag, 7'd10);
    step();
    issue_ready = 1'b0;
    #1;
    chk("t4_freed_occ", occupancy, 4'd7);
    chk("t4_freed_ready", dispatch_ready, 1'b1);
    issue_ready = 1'b1;
    repeat (7) step();
    issue_ready = 1'b0;
    #1;
    chk("t4_drained", occupancy, 4'd0);

    // stall with younger ready entries arriving
    disp(7'h22, 7'd20, 7'd0, 1'b1, 32'h1234, 7'd0, 1'b1, 32'd5);
    step();
    hold_tag = issue_tag;
    hold_rs1 = issue_rs1;
    chk("t5_first_tag", hold_tag, 7'd20);
    for (int i = 1; i <= 3; i++) begin
      disp(7'h22, 7'(20 + i), 7'd0, 1'b1, 32'(i), 7'd0, 1'b1, 32'd0);
      step();
      chk("t5_hold_tag", issue_tag, hold_tag);
      chk("t5_hold_rs1", issue_rs1, hold_rs1);
      chk("t5_hold_valid", issue_valid, 1'b1);
    end
    dispatch_valid = 1'b0;
    issue_ready = 1'b1;
    repeat (4) step();

    // halt freezes both sides
    disp(7'h05, 7'd30, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd2);
    step();
    dispatch_valid = 1'b0;
    halt = 1'b1;
    #1;
    chk("halt_issue", issue_valid, 1'b0);
    chk("halt_dispatch", dispatch_ready, 1'b0);
    step();
    chk("halt_occ", occupancy, 4'd1);
    halt = 1'b0;
    #1;
    chk("unhalt_issue", issue_valid, 1'b1);
    step();

    // async reset with five entries busy
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(7'd9, 7'(40 + i), 7'd0, 1'b1, 32'd3, 7'd0, 1'b1, 32'd4);
      step();
    end
    dispatch_valid = 1'b0;
    chk("t6_pre_occ", occupancy, 4'd5);
    rst = 1'b0;
    broadcastDataAvailable = 1'b1;
    broadcastDestinationTag = 7'd0;
    #1;
    chk("t6_rst_valid", issue_valid, 1'b0);
    chk("t6_rst_occ", occupancy, 4'd0);
    step();
    step();
    broadcastDataAvailable = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_after_occ", occupancy, 4'd0);

    // random traffic checked by the model
    for (int c = 0; c < 300; c++) begin
      disp(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
           7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom,
           7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom);
      dispatch_valid = 1'($urandom_range(0, 1));
      broadcastDataAvailable = 1'($urandom_range(0, 1));
      broadcastDestinationTag = 7'($urandom_range(0, 7));
      broadcastDestinationData = $urandom;
      issue_ready = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 7) == 0);
      step();
    end
    dispatch_valid = 1'b0;
    halt = 1'b0;
    issue_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      broadcastDataAvailable = 1'b1;
      broadcastDestinationTag = 7'(c % 8);
      step();
    end
    broadcastDataAvailable = 1'b0;
    step();
    chk("final_drained", occupancy, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
